// File: rtl/stream_add_hash_if.sv
// Beat-in / hash-out stream bundle for stream_add_hash.
// A transfer happens on a rising edge where valid && ready; valid must not depend on ready.
interface stream_add_hash_if #(
  parameter int DATA_W = 512,
  parameter int HASH_W = 8,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              mode;
  logic              out_valid;
  logic              out_ready;
  logic [HASH_W-1:0] out_hash;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_last, mode, out_ready,
    input  in_ready, out_valid, out_hash, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, mode, out_ready,
    output in_ready, out_valid, out_hash, out_count
  );
endinterface

// File: rtl/stream_add_hash.sv
// Streaming lane-fold hash: folds DATA_W-bit beats into HASH_W-bit lanes (add or xor)
// and holds the final hash plus saturating beat count until the consumer takes it.
module stream_add_hash #(
  parameter int              DATA_W = 512,
  parameter int              HASH_W = 8,
  parameter int              CNT_W  = 16,
  parameter logic [HASH_W-1:0] SEED = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_add_hash_if.slave     bus,
  output logic [1:0]           state_dbg
);

  localparam int LANES = DATA_W / HASH_W;

  if (DATA_W % HASH_W != 0) begin : g_width_check
    $error("stream_add_hash: DATA_W must be a multiple of HASH_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [HASH_W-1:0] acc;
  logic [CNT_W-1:0]  count;
  logic              mode_q;

  logic [HASH_W-1:0] fold_add;
  logic [HASH_W-1:0] fold_xor;
  logic [HASH_W-1:0] acc_base;
  logic [HASH_W-1:0] acc_next;
  logic [CNT_W-1:0]  count_next;
  logic              op_xor;
  logic              accept;

  assign state_dbg    = state;
  assign bus.in_ready = rst_n && (state != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;

  // Lane reduction; each lane add wraps at HASH_W so no carry escapes a lane.
  always_comb begin
    fold_add = '0;
    fold_xor = '0;
    for (int k = 0; k < LANES; k++) begin
      fold_add = fold_add + bus.in_data[HASH_W*k +: HASH_W];
      fold_xor = fold_xor ^ bus.in_data[HASH_W*k +: HASH_W];
    end
  end

  // The first beat of a message starts from SEED and uses the live mode input.
  always_comb begin
    op_xor     = (state == IDLE) ? bus.mode : mode_q;
    acc_base   = (state == IDLE) ? SEED : acc;
    acc_next   = op_xor ? (acc_base ^ fold_xor) : (acc_base + fold_add);
    count_next = count;
    if (state == IDLE) begin
      count_next = CNT_W'(1);
    end else if (count != {CNT_W{1'b1}}) begin
      count_next = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= SEED;
      count         <= '0;
      mode_q        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_hash  <= '0;
      bus.out_count <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (state == IDLE) begin
              mode_q <= bus.mode;
            end
            acc   <= acc_next;
            count <= count_next;
            if (bus.in_last) begin
              state         <= HOLD;
              bus.out_valid <= 1'b1;
              bus.out_hash  <= acc_next;
              bus.out_count <= count_next;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
            acc           <= SEED;
            count         <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
